// File: rtl/dmem_if.sv
// ---------------------------------------------------------------------------
// dmem_if -- load/store bus between the execute stage and the data memory.
//
// Signals:
//   mem_read_en   core -> mem  load request, held until mem_ready
//   mem_write_en  core -> mem  store request, held until mem_ready
//   mem_addr      core -> mem  32-bit word address
//   mem_data_out  core -> mem  store data
//   mem_data_in   mem -> core  load data (holds the last read value)
//   mem_ready     mem -> core  one-cycle completion pulse
//   mem_stall     mem -> core  hold the load/store while an access is pending
//   mem_busy      mem -> core  responder is not idle
//   mem_fault     mem -> core  sticky out-of-range flag
//
// Modports: master = core side, slave = memory responder side.
// ---------------------------------------------------------------------------
interface dmem_if;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_ready;
  logic        mem_stall;
  logic        mem_busy;
  logic        mem_fault;

  modport master (
    output mem_read_en, mem_write_en, mem_addr, mem_data_out,
    input  mem_data_in, mem_ready, mem_stall, mem_busy, mem_fault
  );

  modport slave (
    input  mem_read_en, mem_write_en, mem_addr, mem_data_out,
    output mem_data_in, mem_ready, mem_stall, mem_busy, mem_fault
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder -- data-memory responder for the execute stage load/store
// port. A request is accepted in IDLE, WAIT_CYCLES wait states are inserted,
// and on entry to RESP the write is committed or the read data is returned
// together with a one-cycle mem_ready pulse.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit storage words (power of two, 2..4096)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (control and output registers only;
//          storage contents survive reset)
//   bus    dmem_if.slave: request inputs, data/ready/stall/busy/fault outputs
//
// Optional feature (macro DMEM_BOUNDS_CHECK_EN):
//   defined   -> addresses >= DEPTH_WORDS complete normally but writes are
//                suppressed, reads return 0, and mem_fault is set (sticky).
//   undefined -> address wraps modulo DEPTH_WORDS, mem_fault tied to 0.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            lat_wr;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_wdata;
  logic [31:0]     data_in;
  logic            ready;
  logic            busy;
  logic [31:0]     storage [DEPTH_WORDS];

  logic            req;
  logic            enter_resp;
  logic            cur_wr;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            cur_ok;
  logic            commit_wr;

  assign req = bus.mem_read_en | bus.mem_write_en;

  // RESP is entered straight from IDLE only in the zero-wait build; otherwise
  // from WAIT once the counter has run out.
  assign enter_resp = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd0));

  // In IDLE (zero-wait case) the live request is the one being committed;
  // in WAIT the latched copy is used so input changes are ignored.
  assign cur_wr    = (state == S_IDLE) ? bus.mem_write_en        : lat_wr;
  assign cur_idx   = (state == S_IDLE) ? bus.mem_addr[AW-1:0]    : lat_idx;
  assign cur_wdata = (state == S_IDLE) ? bus.mem_data_out        : lat_wdata;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic lat_ok;
  logic fault;
  logic live_ok;

  assign live_ok = ~|bus.mem_addr[31:AW];
  assign cur_ok  = (state == S_IDLE) ? live_ok : lat_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_ok <= 1'b1;
      fault  <= 1'b0;
    end else begin
      if (state == S_IDLE && req) lat_ok <= live_ok;
      if (enter_resp && !cur_ok)  fault  <= 1'b1;
    end
  end

  assign bus.mem_fault = fault;
`else
  logic unused_hi;

  // Upper address bits only matter for the bounds check.
  assign unused_hi     = ^bus.mem_addr[31:AW];
  assign cur_ok        = 1'b1;
  assign bus.mem_fault = 1'b0;
`endif

  // Gated by rst_n so nothing can commit while reset holds the FSM in IDLE.
  assign commit_wr = rst_n & enter_resp & cur_wr & cur_ok;

  // Request payload latch; data path, no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      lat_idx   <= bus.mem_addr[AW-1:0];
      lat_wdata <= bus.mem_data_out;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_wr) storage[cur_idx] <= cur_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      lat_wr  <= 1'b0;
      data_in <= 32'd0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            // Read and write together is treated as a write.
            lat_wr <= bus.mem_write_en;
            busy   <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
              ready <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (enter_resp && !cur_wr) data_in <= cur_ok ? storage[cur_idx] : 32'd0;
    end
  end

  assign bus.mem_data_in = data_in;
  assign bus.mem_ready   = ready;
  assign bus.mem_busy    = busy;
  assign bus.mem_stall   = req & ~ready;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder -- randomized self-checking bench for dmem_responder.
// Two instances share clock and reset: dut (WAIT_CYCLES=2) and dut_z
// (WAIT_CYCLES=0), both DEPTH_WORDS=256. A word-array reference model tracks
// storage contents, the last read value and the sticky fault per instance.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if b0 ();
  dmem_if b1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0.slave)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl      [2][DEPTH];
  bit          mval     [2][DEPTH];
  logic [31:0] last_rd  [2];
  bit          fault_exp[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_data(int s);
    return s ? b1.mem_data_in : b0.mem_data_in;
  endfunction
  function automatic logic o_ready(int s);
    return s ? b1.mem_ready : b0.mem_ready;
  endfunction
  function automatic logic o_stall(int s);
    return s ? b1.mem_stall : b0.mem_stall;
  endfunction
  function automatic logic o_busy(int s);
    return s ? b1.mem_busy : b0.mem_busy;
  endfunction
  function automatic logic o_fault(int s);
    return s ? b1.mem_fault : b0.mem_fault;
  endfunction

  // Address acceptance rule of the reference model.
  function automatic bit addr_ok(logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return a < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive(input int s, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      b0.mem_read_en = rd; b0.mem_write_en = wr; b0.mem_addr = a; b0.mem_data_out = d;
    end else begin
      b1.mem_read_en = rd; b1.mem_write_en = wr; b1.mem_addr = a; b1.mem_data_out = d;
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      last_rd[s]   = 32'd0;
      fault_exp[s] = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input int s, input string tag);
    chk({tag, "_data"},  o_data(s),  32'd0);
    chk({tag, "_ready"}, o_ready(s), 1'b0);
    chk({tag, "_busy"},  o_busy(s),  1'b0);
    chk({tag, "_stall"}, o_stall(s), 1'b0);
    chk({tag, "_fault"}, o_fault(s), 1'b0);
  endtask

  // One complete access: raise the request, wait (bounded) for mem_ready,
  // check latency/stall/busy and the returned data, then drop the request.
  task automatic access(input int s, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d, input bit scramble);
    int wc, lat, stalls, idx;
    bit got, ok;
    wc     = s ? 0 : W;
    lat    = 0;
    stalls = 1;
    got    = 1'b0;
    idx    = int'(a % DEPTH);
    ok     = addr_ok(a);

    @(negedge clk);
    chk("idle_ready", o_ready(s), 1'b0);
    chk("idle_busy",  o_busy(s),  1'b0);
    drive(s, rd, wr, a, d);
    #1;
    chk("stall_on_req", o_stall(s), 1'b1);

    for (int k = 1; k <= wc + 4 && !got; k++) begin
      @(negedge clk);
      if (o_ready(s)) begin
        got = 1'b1;
        lat = k;
      end else begin
        chk("busy_wait", o_busy(s), 1'b1);
        if (o_stall(s)) stalls++;
        if (scramble) drive(s, rd, wr, $urandom, $urandom);
      end
    end

    chk("latency", lat, wc + 1);
    if (got) begin
      chk("stall_cycles", stalls, wc + 1);
      chk("busy_resp", o_busy(s), 1'b1);
      chk("stall_at_ready", o_stall(s), 1'b0);

      if (wr) begin
        if (ok) begin
          mdl[s][idx]  = d;
          mval[s][idx] = 1'b1;
        end
      end else begin
        last_rd[s] = ok ? mdl[s][idx] : 32'd0;
      end
      if (!ok) fault_exp[s] = 1'b1;

      chk(wr ? "data_hold_on_write" : "read_data", o_data(s), last_rd[s]);
      chk("fault", o_fault(s), fault_exp[s]);
    end
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int s, idx, op;
    bit can_rd;

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    reset_model();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) mval[i][j] = 1'b0;

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst1");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs(0, "post_rst0");
    check_idle_outputs(1, "post_rst1");

    // Write then read, two wait states.
    access(0, 0, 1, 32'd5, 32'hDEAD_BEEF, 0);
    access(0, 1, 0, 32'd5, 32'd0, 0);

    // Zero-wait instance, write then read.
    access(1, 0, 1, 32'd0, 32'd1, 0);
    access(1, 1, 0, 32'd0, 32'd0, 0);

    // Simultaneous read+write acts as a write; then read it back.
    access(0, 1, 1, 32'd7, 32'h0000_1234, 0);
    access(0, 1, 0, 32'd7, 32'd0, 0);

    // Reset during WAIT drops the pending write.
    access(0, 0, 1, 32'd3, 32'h0000_AAAA, 0);
    @(negedge clk);
    drive(0, 0, 1, 32'd3, 32'h0000_5555);
    @(negedge clk);
    chk("midrst_busy_before", o_busy(0), 1'b1);
    rst_n = 1'b0;
    drive(0, 0, 0, 32'd0, 32'd0);
    #1;
    chk("midrst_busy_async", o_busy(0), 1'b0);
    chk("midrst_ready_async", o_ready(0), 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_ready", o_ready(0), 1'b0);
    end
    rst_n = 1'b1;
    reset_model();
    access(0, 1, 0, 32'd3, 32'd0, 0);

    // Out-of-range address against word 0.
    access(0, 0, 1, 32'd0, 32'h0000_0077, 0);
    access(0, 0, 1, 32'd256, 32'd9, 0);
    access(0, 1, 0, 32'd0, 32'd0, 0);

    // Randomized traffic on both instances with input scrambling in WAIT.
    for (int n = 0; n < 80; n++) begin
      s = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a + 32'(DEPTH * $urandom_range(1, 3));
      idx    = int'(a % DEPTH);
      can_rd = !addr_ok(a) || mval[s][idx];
      op     = can_rd ? $urandom_range(0, 2) : 1;
      case (op)
        0:       access(s, 1, 0, a, $urandom, 1);
        1:       access(s, 0, 1, a, $urandom, 1);
        default: access(s, 1, 1, a, $urandom, 1);
      endcase
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
